digit_serial_add_sub: RTL

Parametrised, multi-cycle two's-complement adder/subtractor. It processes operands DIGIT bits per clock, LSB digit first, through one carry-chained digit adder. Operands enter and results leave on valid/ready handshakes. It replaces fixed 4-bit combinational adders wherever wide operands must be handled with a small, fixed-size carry chain.

---
 rtl/digit_serial_pkg.sv | 28 ++
 rtl/digit_adder.sv | 34 +++
 rtl/digit_serial_add_sub.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/digit_serial_pkg.sv
// Shared types and elaboration helpers for the digit-serial add/sub block.
// Holds the control state encoding plus the digit-count and counter-width
// helpers used to size the datapath from WIDTH and DIGIT.
package digit_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of DIGIT-bit slices that make up one WIDTH-bit operand.
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Ceiling log2, never less than 1 so a single-digit build still gets a
  // legal one-bit counter.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry adder slice used once per clock by the serial loop.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the parent decides when the result is consumed.
//
// Ports:
//   a, b      DIGIT-bit addends
//   cin       carry into bit 0
//   sum       DIGIT-bit sum
//   cout      carry out of bit DIGIT-1
//   c_msb_in  carry into bit DIGIT-1 (feeds the signed-overflow flag)
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_add_sub.sv
// Two's-complement add/subtract of WIDTH-bit operands, DIGIT bits per clock.
// Latency: accept at edge T, out_valid high after edge T+WIDTH/DIGIT.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (a, b, sub)
//   a, b                  WIDTH-bit operands
//   sub                   0: a+b, 1: a-b
//   out_valid/out_ready   result handshake (sum, cout, v)
//   sum                   WIDTH-bit result
//   cout                  raw carry out of the MSB (subtract: 1 = no borrow)
//   v                     signed overflow
//   busy                  operation in flight or result pending
//
// Build option: define SATURATE_EN to clamp sum to the most positive or
// most negative value on signed overflow; otherwise sum wraps.
module digit_serial_add_sub
  import digit_serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             v,
  output logic             busy
);

  localparam int ND = num_digits(WIDTH, DIGIT);
  localparam int CW = clog2(ND);

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             v_r;

  logic [DIGIT-1:0] d_sum;
  logic             d_cout;
  logic             d_cmsb;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] sum_shift;
  logic [WIDTH-1:0] sum_final;

  assign last   = (cnt == CW'(ND - 1));
  assign accept = in_valid && (state == IDLE);

  // Operands are shifted right one digit per cycle, so the active digit is
  // always the bottom slice and no variable part-select is needed.
  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a        (a_sh[DIGIT-1:0]),
    .b        (b_sh[DIGIT-1:0]),
    .cin      (carry),
    .sum      (d_sum),
    .cout     (d_cout),
    .c_msb_in (d_cmsb)
  );

  // Each new digit enters at the top and earlier digits move down; after
  // ND cycles digit k sits at bits [k*DIGIT +: DIGIT].
  assign sum_shift = (sum_r >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));

`ifdef SATURATE_EN
  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_POS = ~MOST_NEG;

  // Only meaningful in the final-digit cycle, where d_cout/d_cmsb are the
  // carries around bit WIDTH-1. A set sign bit on the wrapped result means
  // two positives overflowed, so clamp high; a clear one means clamp low.
  always_comb begin
    sum_final = sum_shift;
    if (d_cout ^ d_cmsb) begin
      sum_final = sum_shift[WIDTH-1] ? MOST_POS : MOST_NEG;
    end
  end
`else
  assign sum_final = sum_shift;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      v_r    <= 1'b0;
    end else if (accept) begin
      // Subtract is a + ~b + 1: invert B here and seed the carry with sub.
      a_sh  <= a;
      b_sh  <= b ^ {WIDTH{sub}};
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      carry <= d_cout;
      if (last) begin
        cnt    <= '0;
        sum_r  <= sum_final;
        cout_r <= d_cout;
        v_r    <= d_cout ^ d_cmsb;
      end else begin
        cnt   <= cnt + CW'(1);
        sum_r <= sum_shift;
      end
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign v    = v_r;

endmodule
